// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: default width,
// FSM state encoding and the bit-counter width helper.
package serial_sub_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Counter must reach WIDTH-1 without wrapping; WIDTH >= 2 is assumed.
    function automatic int cnt_width(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// Combinational 1-bit full subtractor: d = a - b - bi, bo = borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = a ^ b ^ bi;
    assign bo = (~a & b) | (~a & bi) | (b & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b - bin, one bit per clock,
// LSB first, through a single full-subtractor cell and a borrow register.
// Handshake: start accepted in IDLE or DONE, busy during SHIFT, one-cycle done.
// Optional build macro SUB_SAT_EN: clamp diff to zero when the final borrow is set.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             brw_q, brw_d;
    logic             bout_q, bout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             cell_d;
    logic             cell_bo;
    logic [WIDTH-1:0] res_next;

    full_subtractor u_cell (
        .a  (opa_q[0]),
        .b  (opb_q[0]),
        .bi (brw_q),
        .d  (cell_d),
        .bo (cell_bo)
    );

    // Result register with the current difference bit shifted in at the MSB.
    assign res_next = {cell_d, res_q[WIDTH-1:1]};

    // Next-state logic: handshake, operand shifting and result capture.
    always_comb begin
        // NOTE: every signal gets a hold default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        cnt_d   = cnt_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        res_d   = res_q;
        diff_d  = diff_q;
        brw_d   = brw_q;
        bout_d  = bout_q;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_SHIFT;
                    opa_d   = a;
                    opb_d   = b;
                    brw_d   = bin;
                    res_d   = '0;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                opa_d = opa_q >> 1;
                opb_d = opb_q >> 1;
                res_d = res_next;
                brw_d = cell_bo;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = ST_DONE;
                    bout_d  = cell_bo;
`ifdef SUB_SAT_EN
                    diff_d  = cell_bo ? '0 : res_next;
`else
                    diff_d  = res_next;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_SHIFT);
        done_d = (state_d == ST_DONE);
    end

    // State and datapath registers; async reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            brw_q   <= 1'b0;
            bout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all flops update from pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            brw_q   <= brw_d;
            bout_q  <= bout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;

endmodule
